// File: rtl/capture_sequencer.sv
// Ping-pong capture sequencer: arms on a settled front end, triggers on a comparator rising
// edge or timeout, writes one DEPTH-sample frame, then swaps banks once the reader is idle.
module capture_sequencer #(
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned TIMEOUT_TICKS = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  stable,
  input  logic                  sig_in,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  rd_busy,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_buf,
  output logic                  rd_buf,
  output logic                  frame_done,
  output logic                  frame_valid,
  output logic                  auto_trig,
  output logic [15:0]           drop_cnt,
  output logic                  capturing
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [15:0]           TMO_LAST  = 16'(TIMEOUT_TICKS - 1);
  localparam logic                  TMO_EN    = (TIMEOUT_TICKS != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_SWAP
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   count, count_nxt;
  logic [15:0]             tmo, tmo_nxt;
  logic                    auto_flag, auto_flag_nxt;
  logic                    sig_q;
  logic                    busy_q;
  logic                    wr_en_nxt;
  logic [ADDR_WIDTH-1:0]   wr_addr_nxt;
  logic [DATA_WIDTH-1:0]   wr_data_nxt;
  logic                    wr_buf_nxt;
  logic                    frame_done_nxt;
  logic                    frame_valid_nxt;
  logic                    auto_trig_nxt;
  logic [15:0]             drop_cnt_nxt;

  logic go;
  logic sig_edge;
  logic busy_rise;

  assign go        = enable & stable;
  assign sig_edge  = adc_valid & sig_in & ~sig_q;
  assign busy_rise = rd_busy & ~busy_q;

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    tmo_nxt         = tmo;
    auto_flag_nxt   = auto_flag;
    wr_en_nxt       = 1'b0;
    wr_addr_nxt     = wr_addr;
    wr_data_nxt     = wr_data;
    wr_buf_nxt      = wr_buf;
    frame_done_nxt  = 1'b0;
    frame_valid_nxt = frame_valid;
    auto_trig_nxt   = auto_trig;
    drop_cnt_nxt    = drop_cnt;

    if (busy_rise) frame_valid_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (go) state_nxt = S_ARM;
      end

      S_ARM: begin
        count_nxt     = '0;
        tmo_nxt       = '0;
        auto_flag_nxt = 1'b0;
        state_nxt     = go ? S_WAIT_TRIG : S_IDLE;
      end

      S_WAIT_TRIG: begin
        if (!go) begin
          state_nxt = S_IDLE;
        end else if (adc_valid) begin
          if (sig_edge || (TMO_EN && (tmo == TMO_LAST))) begin
            // Edge wins over timeout when both occur on the same tick.
            auto_flag_nxt = ~sig_edge;
            wr_en_nxt     = 1'b1;
            wr_addr_nxt   = '0;
            wr_data_nxt   = adc_data;
            count_nxt     = ADDR_WIDTH'(1);
            state_nxt     = S_CAPTURE;
          end else begin
            tmo_nxt = tmo + 16'd1;
          end
        end
      end

      S_CAPTURE: begin
        if (!go) begin
          state_nxt = S_IDLE;
        end else if (adc_valid) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = count;
          wr_data_nxt = adc_data;
          if (count == LAST_ADDR) begin
            state_nxt = S_SWAP;
          end else begin
            count_nxt = count + ADDR_WIDTH'(1);
          end
        end
      end

      S_SWAP: begin
        if (!rd_busy) begin
          wr_buf_nxt      = ~wr_buf;
          frame_done_nxt  = 1'b1;
          frame_valid_nxt = 1'b1;
          auto_trig_nxt   = auto_flag;
          state_nxt       = go ? S_ARM : S_IDLE;
        end else if (adc_valid && (drop_cnt != 16'hFFFF)) begin
          drop_cnt_nxt = drop_cnt + 16'd1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= '0;
      tmo         <= '0;
      auto_flag   <= 1'b0;
      sig_q       <= 1'b0;
      busy_q      <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_buf      <= 1'b0;
      rd_buf      <= 1'b1;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      auto_trig   <= 1'b0;
      drop_cnt    <= '0;
      capturing   <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      tmo         <= tmo_nxt;
      auto_flag   <= auto_flag_nxt;
      if (adc_valid) sig_q <= sig_in;
      busy_q      <= rd_busy;
      wr_en       <= wr_en_nxt;
      wr_addr     <= wr_addr_nxt;
      wr_data     <= wr_data_nxt;
      wr_buf      <= wr_buf_nxt;
      rd_buf      <= ~wr_buf_nxt;
      frame_done  <= frame_done_nxt;
      frame_valid <= frame_valid_nxt;
      auto_trig   <= auto_trig_nxt;
      drop_cnt    <= drop_cnt_nxt;
      capturing   <= (state_nxt == S_CAPTURE);
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: basic, auto-trigger, busy reader, abort, reset, handoff.
module tb_capture_sequencer;

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 10;
  localparam int unsigned TT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          stable;
  logic          sig_in;
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic          rd_busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_buf;
  logic          rd_buf;
  logic          frame_done;
  logic          frame_valid;
  logic          auto_trig;
  logic [15:0]   drop_cnt;
  logic          capturing;

  int checks = 0;
  int passes = 0;
  int fd_cnt = 0;
  int dbl_cnt = 0;
  logic wr_en_prev = 1'b0;

  always #5 clk = ~clk;

  capture_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_TICKS(TT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .stable(stable), .sig_in(sig_in),
    .adc_valid(adc_valid), .adc_data(adc_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_buf(wr_buf),
    .rd_buf(rd_buf), .frame_done(frame_done), .frame_valid(frame_valid),
    .auto_trig(auto_trig), .drop_cnt(drop_cnt), .capturing(capturing)
  );

  // Passive observers: frame_done pulse count and back-to-back write strobes.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (wr_en === 1'b1 && wr_en_prev === 1'b1) dbl_cnt <= dbl_cnt + 1;
    wr_en_prev <= wr_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic [DW-1:0] d, input int gap,
                      output logic we, output logic [AW-1:0] a, output logic [DW-1:0] wd);
    adc_valid = 1'b1;
    adc_data  = d;
    @(negedge clk);
    we = wr_en; a = wr_addr; wd = wr_data;
    adc_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic arm_edge();
    logic we; logic [AW-1:0] a; logic [DW-1:0] wd;
    enable = 1'b1; stable = 1'b1;
    repeat (3) @(negedge clk);
    sig_in = 1'b0;
    tick(DW'(12'hAAA), 2, we, a, wd);
    sig_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; stable = 1'b0; sig_in = 1'b0;
    adc_valid = 1'b0; adc_data = '0; rd_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_en, wr_buf, rd_buf, frame_done, frame_valid, auto_trig, capturing} !== 7'b0010000)
      $display("FAIL reset_flags: got %b want 0010000",
               {wr_en, wr_buf, rd_buf, frame_done, frame_valid, auto_trig, capturing});
    else passes++;
    checks++;
    if (wr_addr !== '0 || wr_data !== '0)
      $display("FAIL reset_wr_bus: got addr %0d data %0d want 0 0", wr_addr, wr_data);
    else passes++;
    checks++;
    if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic we; logic [AW-1:0] a; logic [DW-1:0] wd;
    int bad = 0; int early = 0; int fd0; logic cap_mid = 1'b0;
    fd0 = fd_cnt;
    enable = 1'b1; stable = 1'b1; sig_in = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 1029; i++) begin
      sig_in = (i >= 5);
      tick(DW'(i), 20, we, a, wd);
      if (i < 5) begin
        if (we !== 1'b0) early++;
      end else if (we !== 1'b1 || a !== AW'(i - 5) || wd !== DW'(i)) begin
        bad++;
      end
      if (i == 600) cap_mid = capturing;
    end
    checks++;
    if (early != 0) $display("FAIL basic_pretrigger: %0d writes before edge, want 0", early);
    else passes++;
    checks++;
    if (bad != 0) $display("FAIL basic_writes: %0d wrong writes, want 0", bad);
    else passes++;
    checks++;
    if (cap_mid !== 1'b1) $display("FAIL basic_capturing: got %b want 1", cap_mid);
    else passes++;
    checks++;
    if (fd_cnt - fd0 != 1) $display("FAIL basic_frame_done: got %0d pulses want 1", fd_cnt - fd0);
    else passes++;
    checks++;
    if ({wr_buf, rd_buf, frame_valid, auto_trig, capturing} !== 5'b10100)
      $display("FAIL basic_status: got %b want 10100",
               {wr_buf, rd_buf, frame_valid, auto_trig, capturing});
    else passes++;
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_auto_trigger();
    logic we; logic [AW-1:0] a; logic [DW-1:0] wd;
    int bad = 0; int early = 0; int fd0;
    logic first_ok = 1'b0;
    fd0 = fd_cnt;
    sig_in = 1'b0; enable = 1'b1; stable = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      tick(DW'(100 + i), 2, we, a, wd);
      if (i < 16 && we !== 1'b0) early++;
      if (i == 16) first_ok = (we === 1'b1 && a === '0 && wd === DW'(116));
    end
    checks++;
    if (early != 0) $display("FAIL auto_early: %0d writes before 16th tick, want 0", early);
    else passes++;
    checks++;
    if (first_ok !== 1'b1) $display("FAIL auto_first: got we %b addr %0d data %0d want 1 0 116", we, a, wd);
    else passes++;
    for (int i = 1; i < 1024; i++) begin
      tick(DW'(i), 2, we, a, wd);
      if (we !== 1'b1 || a !== AW'(i) || wd !== DW'(i)) bad++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bad != 0) $display("FAIL auto_writes: %0d wrong writes, want 0", bad);
    else passes++;
    checks++;
    if ({auto_trig, wr_buf, frame_valid} !== 3'b101 || fd_cnt - fd0 != 1)
      $display("FAIL auto_status: got auto %b wr_buf %b fv %b pulses %0d want 1 0 1 1",
               auto_trig, wr_buf, frame_valid, fd_cnt - fd0);
    else passes++;
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reader_busy();
    logic we; logic [AW-1:0] a; logic [DW-1:0] wd;
    int bad = 0; int drops_wr = 0; int fd0;
    fd0 = fd_cnt;
    arm_edge();
    for (int i = 0; i < 1024; i++) begin
      if (i == 1023) rd_busy = 1'b1;
      tick(DW'(i), 2, we, a, wd);
      if (we !== 1'b1 || a !== AW'(i) || wd !== DW'(i)) bad++;
    end
    for (int i = 0; i < 10; i++) begin
      tick(DW'(12'h777), 2, we, a, wd);
      if (we !== 1'b0) drops_wr++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bad != 0 || drops_wr != 0)
      $display("FAIL busy_writes: %0d wrong writes %0d writes in swap, want 0 0", bad, drops_wr);
    else passes++;
    checks++;
    if (drop_cnt !== 16'd10) $display("FAIL busy_drop_cnt: got %0d want 10", drop_cnt);
    else passes++;
    checks++;
    if (wr_buf !== 1'b0 || frame_valid !== 1'b0 || fd_cnt - fd0 != 0)
      $display("FAIL busy_hold: got wr_buf %b fv %b pulses %0d want 0 0 0",
               wr_buf, frame_valid, fd_cnt - fd0);
    else passes++;
    rd_busy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_buf, rd_buf, frame_valid} !== 3'b101)
      $display("FAIL busy_release: got wr_buf %b rd_buf %b fv %b want 1 0 1", wr_buf, rd_buf, frame_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if (fd_cnt - fd0 != 1) $display("FAIL busy_frame_done: got %0d pulses want 1", fd_cnt - fd0);
    else passes++;
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    logic we; logic [AW-1:0] a; logic [DW-1:0] wd;
    int bad = 0; int fd0;
    fd0 = fd_cnt;
    arm_edge();
    for (int i = 0; i < 300; i++) begin
      tick(DW'(i), 2, we, a, wd);
      if (we !== 1'b1 || a !== AW'(i)) bad++;
    end
    stable = 1'b0;
    @(negedge clk);
    checks++;
    if (bad != 0 || capturing !== 1'b0)
      $display("FAIL abort_idle: bad %0d capturing %b want 0 0", bad, capturing);
    else passes++;
    tick(DW'(12'h123), 2, we, a, wd);
    checks++;
    if (we !== 1'b0) $display("FAIL abort_no_write: got wr_en %b want 0", we);
    else passes++;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_buf !== 1'b1 || frame_valid !== 1'b1 || fd_cnt - fd0 != 0)
      $display("FAIL abort_status: got wr_buf %b fv %b pulses %0d want 1 1 0",
               wr_buf, frame_valid, fd_cnt - fd0);
    else passes++;
    arm_edge();
    tick(DW'(12'h055), 2, we, a, wd);
    checks++;
    if (we !== 1'b1 || a !== '0 || wd !== DW'(12'h055))
      $display("FAIL abort_restart: got we %b addr %0d data %0h want 1 0 55", we, a, wd);
    else passes++;
    tick(DW'(12'h056), 2, we, a, wd);
    checks++;
    if (we !== 1'b1 || a !== AW'(1)) $display("FAIL abort_restart2: got we %b addr %0d want 1 1", we, a);
    else passes++;
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_capture();
    logic we; logic [AW-1:0] a; logic [DW-1:0] wd;
    arm_edge();
    for (int i = 0; i < 50; i++) tick(DW'(i + 7), 2, we, a, wd);
    checks++;
    if (capturing !== 1'b1) $display("FAIL midrst_precond: got capturing %b want 1", capturing);
    else passes++;
    rst = 1'b1; adc_valid = 1'b1; adc_data = DW'(12'h3FF);
    @(negedge clk);
    checks++;
    if ({wr_en, wr_buf, rd_buf, frame_done, frame_valid, auto_trig, capturing} !== 7'b0010000)
      $display("FAIL midrst_flags: got %b want 0010000",
               {wr_en, wr_buf, rd_buf, frame_done, frame_valid, auto_trig, capturing});
    else passes++;
    checks++;
    if (wr_addr !== '0 || wr_data !== '0 || drop_cnt !== 16'd0)
      $display("FAIL midrst_values: got addr %0d data %0d drops %0d want 0 0 0", wr_addr, wr_data, drop_cnt);
    else passes++;
    adc_valid = 1'b0; rst = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_handoff();
    logic we; logic [AW-1:0] a; logic [DW-1:0] wd;
    logic exp_buf;
    int bad;
    checks++;
    if (wr_buf !== 1'b0) $display("FAIL handoff_start: got wr_buf %b want 0", wr_buf);
    else passes++;
    for (int f = 0; f < 3; f++) begin
      exp_buf = (f % 2 == 0);
      bad = 0;
      arm_edge();
      for (int i = 0; i < 1023; i++) begin
        tick(DW'(i), 2, we, a, wd);
        if (we !== 1'b1 || a !== AW'(i)) bad++;
      end
      tick(DW'(1023), 1, we, a, wd);
      checks++;
      if (bad != 0 || we !== 1'b1 || a !== AW'(1023) || capturing !== 1'b0 || frame_done !== 1'b0)
        $display("FAIL handoff_last_f%0d: bad %0d we %b addr %0d cap %b fd %b want 0 1 1023 0 0",
                 f, bad, we, a, capturing, frame_done);
      else passes++;
      @(negedge clk);
      checks++;
      if ({frame_done, wr_buf, rd_buf, frame_valid} !== {1'b1, exp_buf, ~exp_buf, 1'b1})
        $display("FAIL handoff_swap_f%0d: got %b want %b", f,
                 {frame_done, wr_buf, rd_buf, frame_valid}, {1'b1, exp_buf, ~exp_buf, 1'b1});
      else passes++;
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0) $display("FAIL handoff_pulse_f%0d: got %b want 0", f, frame_done);
      else passes++;
      rd_busy = 1'b1;
      @(negedge clk);
      checks++;
      if (frame_valid !== 1'b0) $display("FAIL handoff_fv_clear_f%0d: got %b want 0", f, frame_valid);
      else passes++;
      rd_busy = 1'b0;
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dbl_cnt != 0) $display("FAIL wr_en_double: got %0d back-to-back strobes want 0", dbl_cnt);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_auto_trigger();
    test_reader_busy();
    test_abort();
    test_reset_mid_capture();
    test_handoff();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
